// File: rtl/axi_slave_write_mem.sv
// AXI4 write-path slave (AW/W/B) backed by a byte-enabled word memory.
// Supports FIXED/INCR/WRAP bursts, sticky SLVERR on illegal requests,
// and a combinational debug read port into the memory.
// Optional macro AXI_WR_STALL_EN: an lfsr_6 throttles WREADY and BVALID
// to model a slow write buffer.

`ifdef AXI_WR_STALL_EN
// 6-bit maximal-length LFSR (x^6 + x^5 + 1) used as a pseudo-random stall source.
module lfsr_6 (
  input  logic clk,
  input  logic rst_n,
  output logic lfsr_out
);
  logic [5:0] lfsr_reg;

  // Shift every cycle; nonzero seed keeps the sequence alive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_reg <= 6'b000001;
    else        lfsr_reg <= {lfsr_reg[4:0], lfsr_reg[5] ^ lfsr_reg[4]};
  end

  assign lfsr_out = lfsr_reg[0];
endmodule
`endif

module axi_slave_write_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic                         AWVALID,
  input  logic [LEN_WIDTH-1:0]         AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  output logic                         WREADY,
  input  logic                         WVALID,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WLAST,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LOG_B  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    beat_cnt_reg;
  logic [2:0]              size_reg;
  logic [1:0]              burst_reg;
  logic                    err_reg;
  logic                    bad_burst_reg;   // illegal size/burst: suppress all writes
  logic                    awready_reg;
  logic                    wready_reg;
  logic                    bvalid_reg;
  logic [1:0]              bresp_reg;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    stall_ok;
  logic                    bvalid_on_entry;

`ifdef AXI_WR_STALL_EN
  lfsr_6 u_lfsr (.clk(clk), .rst_n(rst_n), .lfsr_out(stall_ok));
  assign bvalid_on_entry = 1'b0;
`else
  assign stall_ok        = 1'b1;
  assign bvalid_on_entry = 1'b1;
`endif

  assign AWREADY   = awready_reg;
  assign WREADY    = wready_reg & stall_ok;
  assign BVALID    = bvalid_reg;
  assign BRESP     = bresp_reg;
  assign dbg_rdata = mem[dbg_addr];

  logic                  w_beat;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_full;
  logic                  addr_ok;
  logic                  beat_err;
  logic                  do_write;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] window;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  aw_bad;

  // Per-beat decode: target word, range check, error and next address.
  always_comb begin
    w_beat    = WVALID && WREADY;
    last_beat = (beat_cnt_reg == len_reg);
    offset    = addr_reg - BASE_ADDR;
    word_full = offset >> LOG_B;
    addr_ok   = (addr_reg >= BASE_ADDR) && ((word_full >> IDX_W) == '0);
    beat_err  = !addr_ok || (WLAST != last_beat);
    do_write  = w_beat && !bad_burst_reg && addr_ok;
    step      = ONE_A << size_reg;
    window    = (ADDR_WIDTH'(len_reg) + ONE_A) << size_reg;
    lower     = addr_reg & ~(window - ONE_A);
    incr_addr = addr_reg + step;
    case (burst_reg)
      2'b00:   next_addr = addr_reg;
      2'b10:   next_addr = (incr_addr == lower + window) ? lower : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

  // Burst-level legality of the incoming AW request.
  always_comb begin
    aw_bad = (AWSIZE > 3'(LOG_B)) || (AWBURST == 2'b11) ||
             ((AWBURST == 2'b10) &&
              !((AWLEN == LEN_WIDTH'(1)) || (AWLEN == LEN_WIDTH'(3)) ||
                (AWLEN == LEN_WIDTH'(7)) || (AWLEN == LEN_WIDTH'(15))));
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      awready_reg   <= 1'b1;
      wready_reg    <= 1'b0;
      bvalid_reg    <= 1'b0;
      bresp_reg     <= 2'b00;
      addr_reg      <= '0;
      len_reg       <= '0;
      size_reg      <= '0;
      burst_reg     <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      bad_burst_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (AWVALID && awready_reg) begin
            addr_reg      <= AWADDR;
            len_reg       <= AWLEN;
            size_reg      <= AWSIZE;
            burst_reg     <= AWBURST;
            beat_cnt_reg  <= '0;
            err_reg       <= aw_bad;
            bad_burst_reg <= aw_bad;
            awready_reg   <= 1'b0;
            wready_reg    <= 1'b1;
            state_reg     <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            addr_reg     <= next_addr;
            beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
            err_reg      <= err_reg | beat_err;
            if (last_beat) begin
              wready_reg <= 1'b0;
              bvalid_reg <= bvalid_on_entry;
              bresp_reg  <= (err_reg | beat_err) ? 2'b10 : 2'b00;
              state_reg  <= RESP;
            end
          end
        end
        RESP: begin
          if (!bvalid_reg) begin
            if (stall_ok) bvalid_reg <= 1'b1;
          end else if (BREADY) begin
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            awready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Byte-enabled memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[word_full[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_write_mem.sv
// Scoreboarded bench for axi_slave_write_mem: expected BRESP values are
// queued as each burst is issued and popped at the B handshake; memory
// contents are compared through the debug port against hand-derived values.
module tb_axi_slave_write_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        WREADY;
  logic        WVALID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_resp_q[$];
  logic [31:0] bdata [16];
  logic [3:0]  bstrb [16];
  logic [15:0] wlast_pat;
  logic        use_pat;

  axi_slave_write_mem dut (
    .clk(clk), .rst_n(rst_n),
    .AWREADY(AWREADY), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WREADY(WREADY), .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BREADY(BREADY), .BRESP(BRESP), .BVALID(BVALID),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_check(input int idx, input logic [31:0] exp);
    dbg_addr = idx[7:0];
    #1;
    check($sformatf("mem[%0d]", idx), dbg_rdata, exp);
  endtask

  // Drives one full AW/W/B transaction; expected BRESP goes to the scoreboard.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input int bready_delay);
    int t;
    logic [1:0] exp;
    exp_resp_q.push_back(exp_resp);
    AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("aw_timeout", 1, 0);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    check("wready_lat", WREADY, 1);
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = bdata[i]; WSTRB = bstrb[i];
      WLAST  = use_pat ? wlast_pat[i] : (i == int'(len));
      t = 0;
      while (!WREADY && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) check("w_timeout", 1, 0);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid_lat", BVALID, 1);
    for (int k = 0; k < bready_delay; k++) begin
      check("bvalid_hold", BVALID, 1);
      check("bresp_hold", BRESP, exp_resp);
      check("awready_busy", AWREADY, 0);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("b_timeout", 1, 0);
    if (exp_resp_q.size() == 0) check("sb_empty", 1, 0);
    else begin
      exp = exp_resp_q.pop_front();
      $display("B handshake addr=%0h len=%0d burst=%0d bresp=%0b", addr, len, burst, BRESP);
      check("bresp", BRESP, exp);
    end
    @(posedge clk); #1;
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
    check("awready_back", AWREADY, 1);
    use_pat = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; AWADDR = '0; AWVALID = 0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0; dbg_addr = '0;
    use_pat = 1'b0; wlast_pat = '0;
    for (int i = 0; i < 16; i++) begin bdata[i] = '0; bstrb[i] = 4'hF; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR 0x10, 4 beats -> words 4..7
    for (int i = 0; i < 4; i++) bdata[i] = 32'hA0 + i;
    run_burst(32'h10, 8'd3, 3'd2, 2'b01, 2'b00, 0);
    mem_check(4, 32'hA0); mem_check(5, 32'hA1); mem_check(6, 32'hA2); mem_check(7, 32'hA3);

    // WRAP 0x18, 4 beats -> words 6,7,4,5
    for (int i = 0; i < 4; i++) bdata[i] = 32'hB0 + i;
    run_burst(32'h18, 8'd3, 3'd2, 2'b10, 2'b00, 0);
    mem_check(6, 32'hB0); mem_check(7, 32'hB1); mem_check(4, 32'hB2); mem_check(5, 32'hB3);

    // Clear word 8, then FIXED byte-lane merge
    bdata[0] = 32'h0;
    run_burst(32'h20, 8'd0, 3'd2, 2'b01, 2'b00, 0);
    bdata[0] = 32'h11;     bstrb[0] = 4'h1;
    bdata[1] = 32'h2200;   bstrb[1] = 4'h2;
    bdata[2] = 32'h330000; bstrb[2] = 4'h4;
    run_burst(32'h20, 8'd2, 3'd2, 2'b00, 2'b00, 0);
    mem_check(8, 32'h00332211);
    for (int i = 0; i < 16; i++) bstrb[i] = 4'hF;

    // Known contents for words 0 and 12..14
    bdata[0] = 32'h12345678;
    run_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00, 0);
    bdata[0] = 32'hC0C0C0C0; bdata[1] = 32'hD0D0D0D0; bdata[2] = 32'hE0E0E0E0;
    run_burst(32'h30, 8'd2, 3'd2, 2'b01, 2'b00, 0);

    // Out of range: index 256 aliases to word 0 if the range check were missing
    bdata[0] = 32'hDEADBEEF;
    run_burst(32'h400, 8'd0, 3'd2, 2'b01, 2'b10, 0);
    mem_check(0, 32'h12345678);
    // Reserved burst type
    run_burst(32'h30, 8'd0, 3'd2, 2'b11, 2'b10, 0);
    mem_check(12, 32'hC0C0C0C0);
    // Oversized beat
    run_burst(32'h34, 8'd0, 3'd3, 2'b01, 2'b10, 0);
    mem_check(13, 32'hD0D0D0D0);
    // WRAP with illegal length
    bdata[1] = 32'hDEADBEEF; bdata[2] = 32'hDEADBEEF;
    run_burst(32'h38, 8'd2, 3'd2, 2'b10, 2'b10, 0);
    mem_check(14, 32'hE0E0E0E0);

    // Early WLAST: beats still written, SLVERR, BREADY held off 5 cycles
    for (int i = 0; i < 3; i++) bdata[i] = 32'hE0 + i;
    use_pat = 1'b1; wlast_pat = 16'b010;
    run_burst(32'h40, 8'd2, 3'd2, 2'b01, 2'b10, 5);
    mem_check(16, 32'hE0); mem_check(17, 32'hE1); mem_check(18, 32'hE2);

    // Reset mid-burst after two beats
    AWADDR = 32'h0; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b0; WDATA = 32'hF0;
    @(posedge clk); #1;
    WDATA = 32'hF1;
    @(posedge clk); #1;
    WVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("Reset mid-burst asserted");
    check("midrst_awready", AWREADY, 1);
    check("midrst_wready", WREADY, 0);
    check("midrst_bvalid", BVALID, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_check(0, 32'hF0); mem_check(1, 32'hF1);

    // Recovery after reset
    bdata[0] = 32'h77;
    run_burst(32'h8, 8'd0, 3'd2, 2'b01, 2'b00, 0);
    mem_check(2, 32'h77);

    check("sb_drained", exp_resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_slave_write_mem.md
Name: axi_slave_write_mem

Overview:
AXI4 write-path slave: AW, W and B channels, backed by an internal byte-addressable memory array.
- Generalised successor of the single-burst write handshake block.
- Adds parametrised data width, WSTRB byte enables, FIXED/INCR/WRAP address generation, memory storage and 2-bit OKAY/SLVERR responses.
- Sits behind the CPU's AXI interconnect as a data-memory / peripheral write target; a debug read port exposes contents to the bench.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, W channel width in bits; power of two, 8..128
LEN_WIDTH, 8, AWLEN width; beats per burst = AWLEN+1
MEM_DEPTH, 256, memory depth in DATA_WIDTH words; power of two
BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  reset; asynchronous, active-low
AWREADY  out  1  write address ready
AWADDR  in  ADDR_WIDTH  burst start byte address
AWVALID  in  1  write address valid
AWLEN  in  LEN_WIDTH  beats minus one
AWSIZE  in  3  bytes per beat = 2^AWSIZE
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WREADY  out  1  write data ready
WVALID  in  1  write data valid
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WLAST  in  1  last beat marker
BREADY  in  1  response ready
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
dbg_addr  in  log2(MEM_DEPTH)  debug word index
dbg_rdata  out  DATA_WIDTH  combinational memory word at dbg_addr

Behaviour:
- Reset values: state IDLE, AWREADY=1, WREADY=0, BVALID=0, BRESP=00. Beat counter, latched address and error flag clear to 0. Memory contents are not reset.
- States:
  - IDLE: AWREADY=1; WREADY=0; BVALID=0. On AWVALID&&AWREADY, latch AWADDR/AWLEN/AWSIZE/AWBURST, clear beat count and err, then go to DATA.
  - DATA: AWREADY=0. WREADY=1, subject to the optional stall. On each W beat (WVALID&&WREADY), write WSTRB-enabled bytes of WDATA to word ((addr-BASE_ADDR)>>log2(DATA_WIDTH/8)), advance addr, increment beat count. On the beat where count==latched len, go to RESP.
  - RESP: BVALID=1; BRESP = err ? 10 : 00; both held stable until BREADY. On BVALID&&BREADY, go to IDLE. AWREADY returns to 1 the following cycle.
- Address advance per beat, with step = 2^size:
  - FIXED: addr unchanged.
  - INCR: addr += step; width wraps modulo 2^ADDR_WIDTH.
  - WRAP: window = (len+1)*step, lower = addr & ~(window-1); next = addr+step, and if next == lower+window then next = lower.
- Error conditions (any one sets sticky err for the burst):
  - size > log2(DATA_WIDTH/8)
  - AWBURST==11
  - WRAP with len not in {1,3,7,15}
  - beat address < BASE_ADDR or word index >= MEM_DEPTH
  - WLAST==1 on a non-final beat, or WLAST==0 on the final beat
- Under err, beats with an illegal burst/size/address are accepted but not written. Beats that are in range with legal burst/size still write when the only fault is a WLAST mismatch.
- Burst length is governed by latched AWLEN, never by WLAST.
- Latency: AW accept→WREADY is 1 cycle. Final W beat→BVALID is 1 cycle. BREADY&&BVALID→AWREADY is 1 cycle.
- One outstanding burst only. AW presented outside IDLE waits with AWREADY=0.
- Simultaneous final W beat and next AWVALID: AW is not accepted until IDLE.
- Reset mid-burst: return immediately to IDLE; bytes already written stay; no B response issued.

Optional Feature:
AXI_WR_STALL_EN
- Defined: instantiate lfsr_6; in DATA, WREADY = lfsr_out; in RESP, BVALID is asserted only once lfsr_out is first high, then held until handshake. Models a slow write buffer.
- Undefined: no LFSR; WREADY=1 throughout DATA; BVALID=1 on entry to RESP.

Test Plan:
- INCR AWADDR=0x10, AWLEN=3, AWSIZE=2, WDATA=0xA0..0xA3, WSTRB=F → words 4..7 = 0xA0..0xA3, BRESP=00, 4 W beats then BVALID next cycle.
- WRAP AWADDR=0x18, AWLEN=3, AWSIZE=2 → beats write words 6,7,4,5; BRESP=00.
- FIXED AWADDR=0x20, AWLEN=2, WSTRB=1,2,4, WDATA=0x11,0x2200,0x330000 → word 8 = 0x00332211; BRESP=00.
- AWADDR=4*MEM_DEPTH, AWLEN=0 → no memory change; BRESP=10. Also AWBURST=11 → BRESP=10.
- AWLEN=2 with WLAST on beat 1 → all 3 beats written, BRESP=10; BREADY held low 5 cycles → BVALID/BRESP stable, AWREADY=0.
- Assert rst_n=0 after beat 1 of a 4-beat INCR → next cycle state IDLE, AWREADY=1, BVALID=0; word 0 keeps beat 0 data.
